// File: rtl/data_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder_if
// Description : Request/response bundle between the core load/store path and
//               the data memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Word-organised data RAM behind a valid/ready request/response
//               handshake with WAIT_STATES+1 cycles of access latency.
//               Define DMEM_BYTE_STROBE_EN to honour req_be on stores.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 2
) (
    input  wire logic          clk,
    input  wire logic          rst,
    data_mem_responder_if.slave bus
);

    localparam int unsigned c_aw      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [29:0] c_depth   = 30'(DEPTH_WORDS);
    localparam logic [3:0]  c_wait    = 4'(WAIT_STATES);

    localparam logic [1:0]  c_st_idle = 2'd0;
    localparam logic [1:0]  c_st_wait = 2'd1;
    localparam logic [1:0]  c_st_resp = 2'd2;

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic        r_write;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;

    logic [31:0] r_mem [DEPTH_WORDS];

    // 33-bit offset: bit 32 flags addresses below BASE_ADDR so wrap cannot alias.
    logic [32:0]     w_off;
    logic            w_err;
    logic [c_aw-1:0] w_idx;
    logic            w_access;
    logic            w_store;
    logic [31:0]     w_wr_word;

    assign w_off    = {1'b0, r_addr} - {1'b0, BASE_ADDR};
    assign w_err    = (r_addr[1:0] != 2'b00) | w_off[32] | (w_off[31:2] >= c_depth);
    assign w_idx    = w_off[c_aw+1:2];
    assign w_access = (r_state == c_st_wait) && (r_cnt == 4'd0);
    assign w_store  = w_access && r_write && !w_err;

`ifdef DMEM_BYTE_STROBE_EN
    always_comb begin
        w_wr_word = r_mem[w_idx];
        for (int b = 0; b < 4; b++) begin
            if (r_be[b]) begin
                w_wr_word[8*b +: 8] = r_wdata[8*b +: 8];
            end
        end
    end

    logic w_unused;
    assign w_unused = ^w_off[1:0];
`else
    assign w_wr_word = r_wdata;

    logic w_unused;
    assign w_unused = ^{w_off[1:0], r_be};
`endif

    // RAM contents survive reset; only the access strobe is gated by state.
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem[w_idx] <= w_wr_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_cnt       <= 4'd0;
            r_write     <= 1'b0;
            r_addr      <= 32'h0;
            r_wdata     <= 32'h0;
            r_be        <= 4'h0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (bus.req_valid) begin
                        r_write <= bus.req_write;
                        r_addr  <= bus.req_addr;
                        r_wdata <= bus.req_wdata;
                        r_be    <= bus.req_be;
                        r_cnt   <= c_wait;
                        r_state <= c_st_wait;
                    end
                end
                c_st_wait: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= w_err;
                        r_rsp_rdata <= (!r_write && !w_err) ? r_mem[w_idx] : 32'h0;
                        r_state     <= c_st_resp;
                    end
                end
                c_st_resp: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_rdata <= 32'h0;
                        r_rsp_err   <= 1'b0;
                        r_state     <= c_st_idle;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign bus.req_ready = (r_state == c_st_idle);
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_responder
// Description : Directed bench: a default instance (base 0, 2 wait states) and
//               an offset instance (base 0x100, 0 wait states).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    data_mem_responder_if bus0 ();
    data_mem_responder_if bus1 ();

    data_mem_responder #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(2)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0.slave)
    );
    data_mem_responder #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0000_0100), .WAIT_STATES(0)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1.slave)
    );

`ifdef DMEM_BYTE_STROBE_EN
    localparam logic [31:0] c_be_exp  = 32'h11BB_33DD;
    localparam logic [31:0] c_be0_exp = 32'h1234_5678;
`else
    localparam logic [31:0] c_be_exp  = 32'hAABB_CCDD;
    localparam logic [31:0] c_be0_exp = 32'h9999_9999;
`endif

    typedef struct packed {
        logic        sel;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    localparam int c_nvec = 26;
    vec_t tbl [c_nvec];

    int n_checks = 0;
    int n_errors = 0;

    logic        m_sel = 1'b0;
    logic        m_rsp_valid, m_req_ready, m_rsp_err;
    logic [31:0] m_rsp_rdata;
    assign m_rsp_valid = m_sel ? bus1.rsp_valid : bus0.rsp_valid;
    assign m_req_ready = m_sel ? bus1.req_ready : bus0.req_ready;
    assign m_rsp_err   = m_sel ? bus1.rsp_err   : bus0.rsp_err;
    assign m_rsp_rdata = m_sel ? bus1.rsp_rdata : bus0.rsp_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic v, input logic wr,
                         input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        if (!s) begin
            bus0.req_valid = v; bus0.req_write = wr; bus0.req_addr = a;
            bus0.req_wdata = wd; bus0.req_be = be;
        end else begin
            bus1.req_valid = v; bus1.req_write = wr; bus1.req_addr = a;
            bus1.req_wdata = wd; bus1.req_be = be;
        end
    endtask

    task automatic set_rsp_ready(input logic s, input logic r);
        if (!s) bus0.rsp_ready = r;
        else    bus1.rsp_ready = r;
    endtask

    // One complete transaction; lat counts edges from accept to rsp_valid.
    task automatic txn(input logic s, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be,
                       output logic [31:0] rd, output logic er, output int lat);
        m_sel = s;
        drive(s, 1'b1, wr, a, wd, be);
        @(posedge clk); #1;
        drive(s, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        lat = 0;
        while (!m_rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = m_rsp_rdata;
        er = m_rsp_err;
        set_rsp_ready(s, 1'b1);
        @(posedge clk); #1;
        set_rsp_ready(s, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;

        bus0.req_valid = 1'b0; bus0.req_write = 1'b0; bus0.req_addr = 32'h0;
        bus0.req_wdata = 32'h0; bus0.req_be = 4'h0; bus0.rsp_ready = 1'b0;
        bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_addr = 32'h0;
        bus1.req_wdata = 32'h0; bus1.req_be = 4'h0; bus1.rsp_ready = 1'b0;

        //          sel   wr    addr          wdata         be    exp_rdata     err
        tbl[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0,        1'b0};
        tbl[1]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         4'hF, 32'hDEAD_BEEF, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 32'h0000_0014, 32'h1234_5678, 4'hF, 32'h0,        1'b0};
        tbl[3]  = '{1'b0, 1'b0, 32'h0000_0014, 32'h0,         4'hF, 32'h1234_5678, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 32'h0000_0012, 32'h0,         4'hF, 32'h0,        1'b1};
        tbl[5]  = '{1'b0, 1'b1, 32'h0000_0012, 32'hFFFF_FFFF, 4'hF, 32'h0,        1'b1};
        tbl[6]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         4'hF, 32'hDEAD_BEEF, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 32'h0000_0400, 32'h0,         4'hF, 32'h0,        1'b1};
        tbl[8]  = '{1'b0, 1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 4'hF, 32'h0,        1'b0};
        tbl[9]  = '{1'b0, 1'b0, 32'h0000_03FC, 32'h0,         4'hF, 32'hCAFE_F00D, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 32'h0000_0000, 32'h1122_3344, 4'hF, 32'h0,        1'b0};
        tbl[11] = '{1'b0, 1'b1, 32'h0000_0000, 32'hAABB_CCDD, 4'h5, 32'h0,        1'b0};
        tbl[12] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         4'hF, c_be_exp,     1'b0};
        tbl[13] = '{1'b0, 1'b1, 32'h0000_0400, 32'hBAD0_0400, 4'hF, 32'h0,        1'b1};
        tbl[14] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         4'hF, c_be_exp,     1'b0};
        tbl[15] = '{1'b0, 1'b1, 32'h0000_0014, 32'h9999_9999, 4'h0, 32'h0,        1'b0};
        tbl[16] = '{1'b0, 1'b0, 32'h0000_0014, 32'h0,         4'hF, c_be0_exp,    1'b0};
        tbl[17] = '{1'b0, 1'b1, 32'h0000_0020, 32'h0BAD_C0DE, 4'hF, 32'h0,        1'b0};
        tbl[18] = '{1'b1, 1'b1, 32'h0000_03FC, 32'hA5A5_A5A5, 4'hF, 32'h0,        1'b0};
        tbl[19] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,         4'hF, 32'h0,        1'b1};
        tbl[20] = '{1'b1, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_0000, 4'hF, 32'h0,        1'b1};
        tbl[21] = '{1'b1, 1'b0, 32'h0000_03FC, 32'h0,         4'hF, 32'hA5A5_A5A5, 1'b0};
        tbl[22] = '{1'b1, 1'b0, 32'h0000_00FC, 32'h0,         4'hF, 32'h0,        1'b1};
        tbl[23] = '{1'b1, 1'b0, 32'h0000_0500, 32'h0,         4'hF, 32'h0,        1'b1};
        tbl[24] = '{1'b1, 1'b1, 32'h0000_04FC, 32'h1357_9BDF, 4'hF, 32'h0,        1'b0};
        tbl[25] = '{1'b1, 1'b0, 32'h0000_04FC, 32'h0,         4'hF, 32'h1357_9BDF, 1'b0};

        // Reset applied between clock edges must take effect at once.
        #2 rst = 1'b1;
        #1;
        chk("reset_req_ready", 32'(bus0.req_ready), 32'd1);
        chk("reset_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
        chk("reset_rsp_rdata", bus0.rsp_rdata, 32'h0);
        chk("reset_rsp_err",   32'(bus0.rsp_err), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < c_nvec; i++) begin
            txn(tbl[i].sel, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].be, rd, er, lat);
            chk($sformatf("row%0d_rdata", i), rd, tbl[i].exp_rdata);
            chk($sformatf("row%0d_err", i), 32'(er), 32'(tbl[i].exp_err));
            chk($sformatf("row%0d_latency", i), 32'(lat), tbl[i].sel ? 32'd1 : 32'd3);
            chk($sformatf("row%0d_post_valid", i), 32'(m_rsp_valid), 32'd0);
            chk($sformatf("row%0d_post_ready", i), 32'(m_req_ready), 32'd1);
        end

        // Reset while a store is still waiting drops the store.
        m_sel = 1'b0;
        drive(1'b0, 1'b1, 1'b1, 32'h20, 32'h55AA_55AA, 4'hF);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        chk("wait_req_ready_low", 32'(bus0.req_ready), 32'd0);
        @(posedge clk); #4;
        rst = 1'b1;
        #1;
        chk("rst_wait_req_ready", 32'(bus0.req_ready), 32'd1);
        chk("rst_wait_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        txn(1'b0, 1'b0, 32'h20, 32'h0, 4'hF, rd, er, lat);
        chk("rst_wait_readback", rd, 32'h0BAD_C0DE);

        // Reset while a response is pending clears the outputs at once.
        drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        lat = 0;
        while (!bus0.rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("resp_rdata_before_rst", bus0.rsp_rdata, 32'hDEAD_BEEF);
        #3 rst = 1'b1;
        #1;
        chk("rst_resp_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
        chk("rst_resp_rsp_rdata", bus0.rsp_rdata, 32'h0);
        chk("rst_resp_req_ready", 32'(bus0.req_ready), 32'd1);
        @(posedge clk); #1 rst = 1'b0;

        // Backpressure: response held, competing request ignored.
        drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
        @(posedge clk); #1;
        lat = 0;
        drive(1'b0, 1'b1, 1'b1, 32'h10, 32'h0000_0000, 4'hF);
        while (!bus0.rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bp_latency", 32'(lat), 32'd3);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk($sformatf("bp%0d_rsp_valid", c), 32'(bus0.rsp_valid), 32'd1);
            chk($sformatf("bp%0d_rsp_rdata", c), bus0.rsp_rdata, 32'hDEAD_BEEF);
            chk($sformatf("bp%0d_rsp_err", c), 32'(bus0.rsp_err), 32'd0);
            chk($sformatf("bp%0d_req_ready", c), 32'(bus0.req_ready), 32'd0);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        bus0.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus0.rsp_ready = 1'b0;
        chk("bp_done_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
        chk("bp_done_rsp_rdata", bus0.rsp_rdata, 32'h0);
        chk("bp_done_req_ready", 32'(bus0.req_ready), 32'd1);
        txn(1'b0, 1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
        chk("bp_store_not_taken", rd, 32'hDEAD_BEEF);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
